// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave = loader side, master = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output s_valid, s_data, input s_ready, wr_en, wr_addr, wr_data);
  modport slave  (input s_valid, s_data, output s_ready, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer: header N, then 4N big-endian bytes.
// Optional IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, LAST, DONE, ERR, CHK} state_t;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, LAST, DONE, ERR} state_t;
`endif

  state_t          state;
  logic [ADDR_W:0] n;
  logic [ADDR_W:0] idx;
  logic [ADDR_W:0] idx_inc;
  logic [1:0]      bcnt;
  logic [23:0]     acc;
  logic            accept;
  logic            hdr_bad;

  assign accept  = bus.s_valid & bus.s_ready;
  assign idx_inc = idx + {{ADDR_W{1'b0}}, 1'b1};
  assign hdr_bad = (bus.s_data == 8'd0) || (int'(bus.s_data) > DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.s_ready <= 1'b0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      n           <= '0;
      idx         <= '0;
      bcnt        <= '0;
      acc         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: if (start) begin
          state       <= HDR;
          bus.s_ready <= 1'b1;
          busy        <= 1'b1;
          core_rst    <= 1'b1;
          done        <= 1'b0;
          err         <= 1'b0;
          idx         <= '0;
          bcnt        <= '0;
        end
        HDR: if (accept) begin
          if (hdr_bad) begin
            state       <= ERR;
            bus.s_ready <= 1'b0;
            busy        <= 1'b0;
            err         <= 1'b1;
          end else begin
            state <= DATA;
            n     <= bus.s_data[ADDR_W:0];
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= bus.s_data;
`endif
        end
        DATA: if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum <= csum ^ bus.s_data;
`endif
          if (bcnt == 2'd3) begin
            bus.wr_en   <= 1'b1;
            bus.wr_data <= {acc, bus.s_data};
            bus.wr_addr <= idx[ADDR_W-1:0];
            idx         <= idx_inc;
            bcnt        <= '0;
            if (idx_inc == n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              // Stream closes here; the trailing cycle lets the last write land
              state       <= LAST;
              bus.s_ready <= 1'b0;
`endif
            end
          end else begin
            acc  <= {acc[15:0], bus.s_data};
            bcnt <= bcnt + 2'd1;
          end
        end
        LAST: begin
          state    <= DONE;
          busy     <= 1'b0;
          core_rst <= 1'b0;
          done     <= 1'b1;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        // Earliest exit is one cycle after the final write strobe
        CHK: if (accept) begin
          bus.s_ready <= 1'b0;
          busy        <= 1'b0;
          if (bus.s_data == csum) begin
            state    <= DONE;
            core_rst <= 1'b0;
            done     <= 1'b1;
          end else begin
            state <= ERR;
            err   <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; byte images built in a queue, writes captured on negedge.
module tb_imem_loader;
  logic clk = 1'b0;
  logic rst, start;
  logic core_rst, busy, done, err;

  imem_loader_if #(.ADDR_W(5)) bus();

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, n_acc = 0, n_ovl = 0;
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  logic [7:0]  img[$];

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready) n_acc++;
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      if (!core_rst) n_ovl++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // all tasks start and end at posedge+1
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit got;
    got = 1'b0;
    bus.s_valid = 1'b0;
    if (gap > 0) cyc(gap);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      got = bus.s_ready;
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_img(input int gap);
    foreach (img[i]) send(img[i], gap);
  endtask

  task automatic do_start;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_end;
    for (int t = 0; t < 20 && !(done || err); t++) cyc(1);
  endtask

  task automatic clr;
    wa.delete();
    wd.delete();
    n_acc = 0;
  endtask

  task automatic push_word(input logic [31:0] w);
    img.push_back(w[31:24]);
    img.push_back(w[23:16]);
    img.push_back(w[15:8]);
    img.push_back(w[7:0]);
  endtask

  task automatic fin_img;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    img.push_back(x);
`endif
  endtask

  task automatic mk_n2;
    img.delete();
    img.push_back(8'h02);
    push_word(32'h200A0005);
    push_word(32'hAC0A0014);
    fin_img();
  endtask

  function automatic logic [31:0] wgen(input int i);
    return {i[7:0], ~i[7:0], i[7:0] + 8'h40, 8'hA5};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad_a, bad_d;
    rst = 1'b1; start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
    cyc(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready",  bus.s_ready, 0);
    chk("rst_wr_en",    bus.wr_en, 0);
    chk("rst_wr_addr",  bus.wr_addr, 0);
    chk("rst_wr_data",  bus.wr_data, 0);
    chk("rst_core_rst", core_rst, 1);
    chk("rst_busy",     busy, 0);
    chk("rst_done",     done, 0);
    chk("rst_err",      err, 0);
    cyc(1);

    // plain N=2 load
    mk_n2(); clr();
    do_start();
    @(negedge clk);
    chk("start_s_ready", bus.s_ready, 1);
    chk("start_busy", busy, 1);
    cyc(1);
    send_img(0);
    wait_end(); cyc(1);
    chk("n2_nwr",   wa.size(), 2);
    chk("n2_addr0", wa[0], 0);
    chk("n2_data0", wd[0], 32'h200A0005);
    chk("n2_addr1", wa[1], 1);
    chk("n2_data1", wd[1], 32'hAC0A0014);
    chk("n2_done",  done, 1);
    chk("n2_core_rst", core_rst, 0);
    chk("n2_busy",  busy, 0);
    chk("n2_acc",   n_acc, img.size());

    // sparse s_valid, one byte every third cycle
    clr();
    do_start();
    send_img(2);
    wait_end(); cyc(1);
    chk("gap_nwr",   wa.size(), 2);
    chk("gap_data0", wd[0], 32'h200A0005);
    chk("gap_data1", wd[1], 32'hAC0A0014);
    chk("gap_acc",   n_acc, img.size());
    chk("gap_done",  done, 1);

    // illegal headers
    clr();
    do_start();
    send(8'h00, 0);
    @(negedge clk);
    chk("h00_err", err, 1);
    chk("h00_s_ready", bus.s_ready, 0);
    chk("h00_core_rst", core_rst, 1);
    chk("h00_busy", busy, 0);
    chk("h00_done", done, 0);
    cyc(1);
    do_start();
    send(8'h21, 0);
    @(negedge clk);
    chk("h21_err", err, 1);
    chk("h21_s_ready", bus.s_ready, 0);
    chk("h21_core_rst", core_rst, 1);
    cyc(3);
    chk("hbad_nwr", wa.size(), 0);
    img.delete(); img.push_back(8'h01); push_word(32'h12345678); fin_img();
    clr();
    do_start();
    send_img(0);
    wait_end(); cyc(1);
    chk("recover_done", done, 1);
    chk("recover_err", err, 0);
    chk("recover_data", wd[0], 32'h12345678);

    // reset in the middle of word 0
    do_start();
    send(8'h02, 0); send(8'h20, 0); send(8'h0A, 0);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_s_ready", bus.s_ready, 0);
    chk("mrst_wr_data", bus.wr_data, 0);
    chk("mrst_core_rst", core_rst, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    cyc(1);
    img.delete(); img.push_back(8'h01); push_word(32'hDEADBEEF); fin_img();
    clr();
    do_start();
    send_img(0);
    wait_end(); cyc(1);
    chk("mrst_nwr", wa.size(), 1);
    chk("mrst_addr", wa[0], 0);
    chk("mrst_data", wd[0], 32'hDEADBEEF);
    chk("mrst_load_done", done, 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    mk_n2();
    img[img.size()-1] = img[img.size()-1] ^ 8'h01;
    clr();
    do_start();
    send_img(0);
    wait_end(); cyc(1);
    chk("badsum_err", err, 1);
    chk("badsum_done", done, 0);
    chk("badsum_nwr", wa.size(), 2);
    chk("badsum_core_rst", core_rst, 1);
`else
    mk_n2(); clr();
    do_start();
    send_img(0);
    bus.s_valid = 1'b1; bus.s_data = 8'h55;
    cyc(5);
    chk("extra_acc", n_acc, 9);
    chk("extra_s_ready", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    chk("extra_done", done, 1);
`endif

    // start during DATA is ignored
    mk_n2(); clr();
    do_start();
    send(img[0], 0); send(img[1], 0); send(img[2], 0);
    do_start();
    for (int i = 3; i < img.size(); i++) send(img[i], 0);
    wait_end(); cyc(1);
    chk("sdata_nwr", wa.size(), 2);
    chk("sdata_data1", wd[1], 32'hAC0A0014);
    chk("sdata_done", done, 1);

    // start in DONE, then full-depth image
    img.delete(); img.push_back(8'h20);
    for (int i = 0; i < 32; i++) push_word(wgen(i));
    fin_img();
    clr();
    do_start();
    @(negedge clk);
    chk("sdone_core_rst", core_rst, 1);
    chk("sdone_done", done, 0);
    chk("sdone_s_ready", bus.s_ready, 1);
    cyc(1);
    send_img(0);
    wait_end(); cyc(1);
    bad_a = 0; bad_d = 0;
    foreach (wa[i]) begin
      if (wa[i] !== i[4:0]) bad_a++;
      if (wd[i] !== wgen(i)) bad_d++;
    end
    chk("fill_nwr", wa.size(), 32);
    chk("fill_addr_bad", bad_a, 0);
    chk("fill_data_bad", bad_d, 0);
    chk("fill_last_addr", wa[31], 31);
    chk("fill_done", done, 1);
    chk("wr_while_core_run", n_ovl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
